// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Shares one sram-like master port between the CPU instruction port (inst_*)
//   and data port (data_*). One outstanding transaction at a time. Data has
//   fixed priority; a starvation counter forces an instruction grant after
//   STARVE_LIMIT consecutive data grants while inst_req is pending.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   inst_req/wr/size/addr     instruction request side (inputs)
//   inst_rdata/addr_ok/data_ok instruction responses (outputs)
//   data_req/wr/size/addr/wdata data request side (inputs)
//   data_rdata/addr_ok/data_ok data responses (outputs)
//   m_req/wr/size/addr/wdata  master request (outputs, registered)
//   m_rdata/addr_ok/data_ok   slave responses (inputs)
//   busy                      state != IDLE
//   err_stray                 sticky: slave data_ok with no accepted transaction
module sram_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic        busy,
  output logic        err_stray
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StAddr = 2'd1;
  localparam logic [1:0] StData = 2'd2;

  localparam logic OwnData = 1'b0;
  localparam logic OwnInst = 1'b1;

  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  starve_q, starve_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        stray_q, stray_d;

  logic in_idle, in_addr, in_data;
  logic addr_acc, done, arb_en;
  logic inst_pend, data_pend, gnt_inst, gnt_data, gnt_any;

  always_comb begin
    in_idle  = (state_q == StIdle);
    in_addr  = (state_q == StAddr);
    in_data  = (state_q == StData);
    addr_acc = in_addr & m_addr_ok;
    // Transaction completes either in DATA or on a same-cycle addr+data accept.
    done     = m_data_ok & (in_data | addr_acc);
    arb_en   = in_idle | done;
    // On a same-cycle accept the owner's req is the one just accepted, not a new one.
    inst_pend = inst_req & ~(addr_acc & (owner_q == OwnInst));
    data_pend = data_req & ~(addr_acc & (owner_q == OwnData));
    gnt_inst  = arb_en & inst_pend & (~data_pend | (starve_q == Limit));
    gnt_data  = arb_en & data_pend & ~gnt_inst;
    gnt_any   = gnt_inst | gnt_data;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    wr_d     = wr_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    stray_d  = stray_q | (m_data_ok & (in_idle | (in_addr & ~m_addr_ok)));

    unique case (state_q)
      StIdle:  state_d = gnt_any ? StAddr : StIdle;
      StAddr: begin
        if (addr_acc && m_data_ok) state_d = gnt_any ? StAddr : StIdle;
        else if (addr_acc)         state_d = StData;
        else                       state_d = StAddr;
      end
      StData: begin
        if (m_data_ok) state_d = gnt_any ? StAddr : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (gnt_inst) begin
      owner_d  = OwnInst;
      wr_d     = inst_wr;
      size_d   = inst_size;
      addr_d   = inst_addr;
      wdata_d  = 32'h0;
      starve_d = 4'd0;
    end else if (gnt_data) begin
      owner_d = OwnData;
      wr_d    = data_wr;
      size_d  = data_size;
      addr_d  = data_addr;
      wdata_d = data_wdata;
      if (!inst_pend)             starve_d = 4'd0;
      else if (starve_q != Limit) starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      owner_q  <= OwnData;
      starve_q <= 4'd0;
      wr_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      stray_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      stray_q  <= stray_d;
    end
  end

  always_comb begin
    m_req        = in_addr;
    m_wr         = wr_q;
    m_size       = size_q;
    m_addr       = addr_q;
    m_wdata      = wdata_q;
    busy         = ~in_idle;
    err_stray    = stray_q;
    inst_addr_ok = addr_acc & (owner_q == OwnInst);
    data_addr_ok = addr_acc & (owner_q == OwnData);
    inst_data_ok = done & (owner_q == OwnInst);
    data_data_ok = done & (owner_q == OwnData);
    inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
    data_rdata   = data_data_ok ? m_rdata : 32'h0;
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
module tb_sram_bus_arbiter;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_addr_ok, m_data_ok;
  logic        busy, err_stray;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        own_inst;
    logic [31:0] addr;
  } grant_t;

  grant_t      exp_gnt_q[$];
  logic [31:0] exp_rdata_q[$];

  sram_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rstn(rstn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok),
    .busy(busy), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; outputs are read 1 unit later.
  task automatic next_cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    m_rdata = 0; m_addr_ok = 0; m_data_ok = 0;
  endtask

  task automatic apply_reset();
    rstn = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle_inputs();
    #1;
    checks++;
    if ({m_req, m_wr, m_size, busy, err_stray} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 000000", {m_req, m_wr, m_size, busy, err_stray});
    end
    checks++;
    if ({m_addr, m_wdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_fields: got %h, expected 0", {m_addr, m_wdata});
    end
    checks++;
    if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0 ||
        inst_rdata !== 32'h0 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_ok: got %b, expected 0000",
               {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok});
    end
    apply_reset();
  endtask

  task automatic test_single_load();
    logic [31:0] exp;
    data_req = 1; data_addr = 32'h0000_1000; data_wr = 0; data_size = 2'b10;
    exp_gnt_q.push_back('{1'b0, 32'h0000_1000});
    exp_rdata_q.push_back(32'hDEAD_BEEF);
    #1;
    checks++;
    if (m_req !== 1'b0) begin errors++; $display("FAIL load_c0_mreq: got %b, expected 0", m_req); end
    next_cyc(); #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h0000_1000 || m_wr !== 1'b0) begin
      errors++;
      $display("FAIL load_c1_addr: got req=%b addr=%h wr=%b, expected 1 00001000 0", m_req, m_addr, m_wr);
    end
    next_cyc(); m_addr_ok = 1; #1;
    if (exp_gnt_q.size() == 0) begin
      checks++; errors++; $display("FAIL load_gnt_q: got empty, expected entry");
    end else begin
      grant_t g;
      g = exp_gnt_q.pop_front();
      checks++;
      if (m_req !== 1'b1 || data_addr_ok !== !g.own_inst || inst_addr_ok !== g.own_inst ||
          m_addr !== g.addr) begin
        errors++;
        $display("FAIL load_c2_addr_ok: got req=%b d_ok=%b i_ok=%b addr=%h, expected 1 1 0 %h",
                 m_req, data_addr_ok, inst_addr_ok, m_addr, g.addr);
      end
    end
    next_cyc(); m_addr_ok = 0; data_req = 0; #1;
    checks++;
    if (m_req !== 1'b0 || busy !== 1'b1 || data_addr_ok !== 1'b0) begin
      errors++;
      $display("FAIL load_c3_wait: got req=%b busy=%b aok=%b, expected 0 1 0", m_req, busy, data_addr_ok);
    end
    next_cyc(); m_data_ok = 1; m_rdata = 32'hDEAD_BEEF; #1;
    exp = (exp_rdata_q.size() != 0) ? exp_rdata_q.pop_front() : 32'hx;
    checks++;
    if (data_data_ok !== 1'b1 || data_rdata !== exp) begin
      errors++;
      $display("FAIL load_c4_data: got ok=%b rdata=%h, expected 1 %h", data_data_ok, data_rdata, exp);
    end
    checks++;
    if ({inst_addr_ok, inst_data_ok} !== 2'b0 || inst_rdata !== 32'h0) begin
      errors++;
      $display("FAIL load_c4_inst_quiet: got %b %h, expected 00 0", {inst_addr_ok, inst_data_ok}, inst_rdata);
    end
    next_cyc(); m_data_ok = 0; m_rdata = 0; #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL load_c5_idle: got busy=%b, expected 0", busy); end
  endtask

  task automatic test_contention();
    int grants = 0;
    int rd = 0;
    logic bump_data = 0, drop_inst = 0, prev_done = 0, cur_inst = 0;
    exp_gnt_q.push_back('{1'b0, 32'h2000});
    exp_gnt_q.push_back('{1'b0, 32'h2004});
    exp_gnt_q.push_back('{1'b0, 32'h2008});
    exp_gnt_q.push_back('{1'b0, 32'h200C});
    exp_gnt_q.push_back('{1'b1, 32'h0100});
    exp_gnt_q.push_back('{1'b0, 32'h2010});
    inst_req = 1; inst_addr = 32'h0100; inst_size = 2'b10;
    data_req = 1; data_addr = 32'h2000; data_size = 2'b10;
    for (int cyc = 0; cyc < 60 && (grants < 6 || busy); cyc++) begin
      if (bump_data) begin
        data_addr = data_addr + 32'd4;
        if (grants == 6) data_req = 0;
      end
      if (drop_inst) inst_req = 0;
      if (prev_done && grants < 6) begin
        checks++;
        if (m_req !== 1'b1) begin
          errors++; $display("FAIL contention_bubble: got m_req=%b, expected 1 (grant %0d)", m_req, grants);
        end
      end
      m_addr_ok = m_req;
      m_data_ok = busy & ~m_req;
      m_rdata   = 32'hA000_0000 + 32'(rd);
      if (m_data_ok) begin
        exp_rdata_q.push_back(m_rdata);
        rd++;
      end
      #1;
      bump_data = 0;
      drop_inst = 0;
      if (inst_addr_ok || data_addr_ok) begin
        grants++;
        if (exp_gnt_q.size() == 0) begin
          checks++; errors++; $display("FAIL contention_extra_grant: got grant %0d, expected none", grants);
        end else begin
          grant_t g;
          g = exp_gnt_q.pop_front();
          checks++;
          if (inst_addr_ok !== g.own_inst || data_addr_ok !== !g.own_inst || m_addr !== g.addr) begin
            errors++;
            $display("FAIL contention_grant%0d: got inst=%b addr=%h, expected inst=%b addr=%h",
                     grants, inst_addr_ok, m_addr, g.own_inst, g.addr);
          end
          cur_inst = g.own_inst;
        end
        bump_data = data_addr_ok;
        drop_inst = inst_addr_ok;
      end
      if (m_data_ok) begin
        logic [31:0] exp;
        exp = exp_rdata_q.pop_front();
        checks++;
        if ((cur_inst ? {inst_data_ok, data_data_ok} : {data_data_ok, inst_data_ok}) !== 2'b10 ||
            (cur_inst ? inst_rdata : data_rdata) !== exp ||
            (cur_inst ? data_rdata : inst_rdata) !== 32'h0) begin
          errors++;
          $display("FAIL contention_rdata: got i_ok=%b d_ok=%b i=%h d=%h, expected owner inst=%b data %h",
                   inst_data_ok, data_data_ok, inst_rdata, data_rdata, cur_inst, exp);
        end
      end
      prev_done = m_data_ok;
      next_cyc();
    end
    idle_inputs();
    checks++;
    if (grants != 6 || exp_gnt_q.size() != 0) begin
      errors++;
      $display("FAIL contention_count: got %0d grants, expected 6", grants);
    end
    exp_gnt_q.delete();
    exp_rdata_q.delete();
  endtask

  task automatic test_store();
    data_req = 1; data_wr = 1; data_size = 2'b10; data_wdata = 32'h1234_5678; data_addr = 32'h4000;
    next_cyc();
    // Scramble the requester fields: the latched copy must not follow them.
    data_wdata = 32'hFFFF_0000; data_size = 2'b00; data_wr = 0;
    for (int i = 0; i < 3; i++) begin
      m_addr_ok = (i == 2);
      #1;
      checks++;
      if (m_req !== 1'b1 || m_wr !== 1'b1 || m_size !== 2'b10 || m_wdata !== 32'h1234_5678 ||
          m_addr !== 32'h4000) begin
        errors++;
        $display("FAIL store_hold%0d: got req=%b wr=%b size=%b wdata=%h, expected 1 1 10 12345678",
                 i, m_req, m_wr, m_size, m_wdata);
      end
      if (i == 2) begin
        checks++;
        if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL store_addr_ok: got %b, expected 1", data_addr_ok); end
      end
      next_cyc();
    end
    data_req = 0; m_addr_ok = 0; m_data_ok = 1;
    #1;
    checks++;
    if (data_data_ok !== 1'b1) begin errors++; $display("FAIL store_data_ok: got %b, expected 1", data_data_ok); end
    next_cyc(); m_data_ok = 0;
  endtask

  task automatic test_same_cycle();
    inst_req = 1; inst_addr = 32'h0300; inst_wr = 0; inst_size = 2'b10;
    next_cyc();
    m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h0300 || m_wdata !== 32'h0 || m_wr !== 1'b0) begin
      errors++;
      $display("FAIL same_fields: got req=%b addr=%h wdata=%h wr=%b, expected 1 00000300 0 0",
               m_req, m_addr, m_wdata, m_wr);
    end
    checks++;
    if ({inst_addr_ok, inst_data_ok} !== 2'b11 || inst_rdata !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL same_inst_pulses: got %b %h, expected 11 cafef00d", {inst_addr_ok, inst_data_ok}, inst_rdata);
    end
    checks++;
    if ({data_addr_ok, data_data_ok} !== 2'b00 || data_rdata !== 32'h0) begin
      errors++;
      $display("FAIL same_data_quiet: got %b %h, expected 00 0", {data_addr_ok, data_data_ok}, data_rdata);
    end
    next_cyc(); inst_req = 0; m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || m_req !== 1'b0 || err_stray !== 1'b0) begin
      errors++;
      $display("FAIL same_idle: got busy=%b req=%b stray=%b, expected 0 0 0", busy, m_req, err_stray);
    end
  endtask

  task automatic test_stray();
    m_data_ok = 1; m_rdata = 32'h1111_1111;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00 || data_rdata !== 32'h0) begin
      errors++; $display("FAIL stray_pulse: got %b, expected 00", {inst_data_ok, data_data_ok});
    end
    next_cyc(); m_data_ok = 0; m_rdata = 0;
    #1;
    checks++;
    if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_set: got %b, expected 1", err_stray); end
    repeat (3) next_cyc();
    #1;
    checks++;
    if (err_stray !== 1'b1) begin errors++; $display("FAIL stray_sticky: got %b, expected 1", err_stray); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    #1;
    checks++;
    if (err_stray !== 1'b0) begin errors++; $display("FAIL rmid_clear: got %b, expected 0", err_stray); end
    data_req = 1; data_addr = 32'h5000;
    next_cyc(); m_addr_ok = 1;
    next_cyc(); m_addr_ok = 0; data_req = 0;
    #1;
    checks++;
    if (busy !== 1'b1 || m_req !== 1'b0) begin
      errors++; $display("FAIL rmid_in_data: got busy=%b req=%b, expected 1 0", busy, m_req);
    end
    rstn = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || m_req !== 1'b0 || m_addr !== 32'h0) begin
      errors++; $display("FAIL rmid_async: got busy=%b req=%b addr=%h, expected 0 0 0", busy, m_req, m_addr);
    end
    next_cyc(); rstn = 1;
    m_data_ok = 1; m_rdata = 32'h7777_7777;
    #1;
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00 || data_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_late_pulse: got %b %h, expected 00 0", {inst_data_ok, data_data_ok}, data_rdata);
    end
    next_cyc(); m_data_ok = 0; m_rdata = 0;
    #1;
    checks++;
    if (err_stray !== 1'b1) begin errors++; $display("FAIL rmid_stray: got %b, expected 1", err_stray); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    apply_reset();
    test_contention();
    apply_reset();
    test_store();
    test_same_cycle();
    test_stray();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_bus_arbiter.md
Name: sram_bus_arbiter

Overview:
- Shares one sram-like master port between the CPU instruction port (inst_*) and data port (data_*).
- Sits between the pipeline's fetch/memory stages and the external AXI bridge.
- Allows one outstanding transaction. Data side has fixed priority, with a starvation guard for instruction fetch.
- Routes addr_ok, data_ok and rdata back to the granted requester only.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req is pending before inst is forced a grant (1..15)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
inst_req  in  1  instruction request; held until inst_addr_ok
inst_wr  in  1  write flag (expected 0)
inst_size  in  2  transfer size
inst_addr  in  32  fetch address
inst_rdata  out  32  fetch data, valid with inst_data_ok
inst_addr_ok  out  1  address accepted pulse
inst_data_ok  out  1  data returned pulse
data_req  in  1  data request; held until data_addr_ok
data_wr  in  1  1=store, 0=load
data_size  in  2  transfer size
data_addr  in  32  data address
data_wdata  in  32  store data
data_rdata  out  32  load data, valid with data_data_ok
data_addr_ok  out  1  address accepted pulse
data_data_ok  out  1  data returned pulse
m_req  out  1  master request
m_wr  out  1  master write flag
m_size  out  2  master size
m_addr  out  32  master address
m_wdata  out  32  master write data
m_rdata  in  32  slave read data
m_addr_ok  in  1  slave address accept
m_data_ok  in  1  slave data return
busy  out  1  state != IDLE
err_stray  out  1  sticky: m_data_ok seen with no accepted transaction

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rstn.
- Reset state:
  - state=IDLE, owner=DATA, starve_cnt=0, err_stray=0.
  - Latched request registers are 0, so m_* are 0.
  - All *_ok outputs are 0. busy=0.
- States:
  - IDLE: no master request.
  - ADDR: m_req=1, driving the latched request fields.
  - DATA: waiting for m_data_ok.
- Arbitration runs in IDLE, and in DATA on the m_data_ok cycle:
  - Only data_req: grant DATA.
  - Only inst_req: grant INST.
  - Both: grant INST if starve_cnt==STARVE_LIMIT, else grant DATA.
  - On grant, latch wr/size/addr/wdata of the winner and owner. Next state is ADDR.
  - inst_wdata does not exist; m_wdata is latched as 0 for inst grants.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each DATA grant while inst_req=1.
  - Clears on any INST grant, or on any grant while inst_req=0.
- Latency: a request first seen in IDLE at cycle N gives m_req=1 at N+1.
- Address phase (ADDR):
  - When m_addr_ok=1, the owner's *_addr_ok=1 in the same cycle (combinational).
  - The requester must drop or advance its req after that edge.
  - Next state is DATA, or see the simultaneous case below.
- Data phase (DATA):
  - When m_data_ok=1, the owner's *_data_ok=1 in the same cycle and owner rdata = m_rdata.
  - The other requester's rdata holds 0.
  - Next state is ADDR if a pending request is granted in that cycle (no bubble), else IDLE.
- Simultaneous m_addr_ok and m_data_ok in ADDR:
  - Both the addr_ok and data_ok pulses go to the owner.
  - The transaction completes and arbitration runs as in DATA.
- Non-owner *_ok outputs are always 0.
- m_data_ok in IDLE, or in ADDR without m_addr_ok, is ignored and sets err_stray. err_stray clears only on reset.
- m_req stays asserted while in ADDR regardless of requester changes. Latched fields are stable until m_addr_ok.
- Reset mid-transaction:
  - Immediate return to IDLE with outputs at reset values.
  - Late slave responses after reset are treated as stray.

Test Plan:
1. Single load: data_req=1, data_addr=0x0000_1000, data_wr=0; slave gives addr_ok at cycle 2 and data_ok with m_rdata=0xDEAD_BEEF at cycle 4 -> m_req high cycles 1-2, data_addr_ok pulse at cycle 2, data_data_ok and data_rdata=0xDEAD_BEEF at cycle 4, inst_* stay 0.
2. Contention: inst_req and data_req both held with STARVE_LIMIT=4 and back-to-back data requests -> grant sequence D,D,D,D,I. No idle cycle between transactions when the slave returns data_ok with a request pending.
3. Store passthrough: data_wr=1, data_size=2'b10, data_wdata=0x1234_5678 -> m_wr=1, m_size=2'b10, m_wdata=0x1234_5678 held from ADDR entry until m_addr_ok.
4. Same-cycle addr_ok and data_ok on an inst fetch -> inst_addr_ok and inst_data_ok both pulse that cycle; state returns to IDLE with busy=0 the next cycle.
5. Stray response: m_data_ok=1 in IDLE -> err_stray=1 and stays 1; no *_data_ok pulse is produced.
6. Reset mid-DATA: rstn low during DATA -> m_req=0, busy=0 asynchronously. A subsequent m_data_ok sets err_stray and produces no requester pulse.
